// File: rtl/spi_bus_bridge.sv
// SPI-to-Xosera register bus bridge: parses command/payload bytes from the SPI target,
// queues bus cycles in a small FIFO and replays them with a fixed CS hold and gap.
module spi_bus_bridge #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [7:0]  IDLE_BYTE  = 8'hCB
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       spi_select_i,
  input  logic       spi_rx_strobe_i,
  input  logic [7:0] spi_rx_byte_i,
  output logic [7:0] spi_tx_byte_o,
  output logic       bus_cs_n_o,
  output logic       bus_rd_nwr_o,
  output logic       bus_bytesel_o,
  output logic [3:0] bus_reg_num_o,
  output logic [7:0] bus_data_o,
  input  logic [7:0] bus_data_i,
  output logic       soft_reset_o,
  output logic       overrun_o
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned MaxHold = (CS_HOLD > GAP_CYCLES) ? CS_HOLD : GAP_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxHold) + 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(CS_HOLD - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [PtrW:0]   PtrOne   = (PtrW + 1)'(1);

  typedef struct packed {
    logic       rd_nwr;
    logic [3:0] reg_num;
    logic       bs;
    logic [7:0] data;
  } entry_t;

  typedef enum logic {StCmd, StPayload} parse_e;
  typedef enum logic [1:0] {StIdle, StActive, StGap} seq_e;

  parse_e pstate_q, pstate_d;
  logic   wr_q, wr_d, ai_q, ai_d, csb_q, csb_d, lane_q, lane_d;
  logic [3:0] reg_q, reg_d;

  entry_t        mem_q [FIFO_DEPTH];
  logic [PtrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          empty, full, push, pop, enq, cmd_seen, capture;
  entry_t        enq_entry, head;

  seq_e            sstate_q, sstate_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cs_n_q, cs_n_d, rd_nwr_q, rd_nwr_d, bs_out_q, bs_out_d;
  logic [3:0]      reg_out_q, reg_out_d;
  logic [7:0]      data_out_q, data_out_d, tx_q, tx_d;
  logic            soft_q, soft_d, ovr_q, ovr_d;

  logic [3:0] pos_reg;
  logic       pos_bs, adv;

  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q ^ rptr_q) == {1'b1, {PtrW{1'b0}}});
  assign head  = mem_q[rptr_q[PtrW-1:0]];

  // Command/payload parser: decides what to enqueue and advances the (REG, BS) position.
  always_comb begin
    pstate_d  = pstate_q;
    wr_d      = wr_q;
    ai_d      = ai_q;
    csb_d     = csb_q;
    lane_d    = lane_q;
    reg_d     = reg_q;
    enq       = 1'b0;
    enq_entry = '0;
    cmd_seen  = 1'b0;
    soft_d    = 1'b0;
    adv       = 1'b0;
    pos_reg   = reg_q;
    pos_bs    = lane_q;
    if (spi_rx_strobe_i) begin
      if (pstate_q == StCmd) begin
        cmd_seen  = 1'b1;
        csb_d     = spi_rx_byte_i[7];
        wr_d      = spi_rx_byte_i[6];
        soft_d    = spi_rx_byte_i[5];
        ai_d      = spi_rx_byte_i[4];
        reg_d     = spi_rx_byte_i[3:0];
        lane_d    = 1'b0;
        pstate_d  = StPayload;
        pos_reg   = spi_rx_byte_i[3:0];
        pos_bs    = 1'b0;
        if (spi_rx_byte_i[7] && !spi_rx_byte_i[6]) begin
          enq       = 1'b1;
          enq_entry = '{rd_nwr: 1'b1, reg_num: pos_reg, bs: 1'b0, data: 8'h00};
          adv       = 1'b1;
        end
      end else if (csb_q) begin
        enq       = 1'b1;
        enq_entry = '{rd_nwr: !wr_q, reg_num: reg_q, bs: lane_q,
                      data: wr_q ? spi_rx_byte_i : 8'h00};
        adv       = 1'b1;
      end
    end
    // BS 0->1 never bumps REG, so the stale AI is harmless on the prefetch path.
    if (adv) begin
      lane_d = !pos_bs;
      if (pos_bs && ai_q) reg_d = pos_reg + 4'd1;
    end
    if (!spi_select_i) pstate_d = StCmd;
  end

  // Bus sequencer: IDLE -> ACTIVE (CS low) -> GAP (CS high, fields held) -> IDLE/ACTIVE.
  always_comb begin
    sstate_d   = sstate_q;
    cnt_d      = cnt_q;
    cs_n_d     = cs_n_q;
    rd_nwr_d   = rd_nwr_q;
    bs_out_d   = bs_out_q;
    reg_out_d  = reg_out_q;
    data_out_d = data_out_q;
    pop        = 1'b0;
    capture    = 1'b0;
    unique case (sstate_q)
      StIdle: pop = !empty;
      StActive: begin
        if (cnt_q == HoldLast) begin
          sstate_d = StGap;
          cnt_d    = '0;
          cs_n_d   = 1'b1;
          capture  = rd_nwr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          pop = !empty;
          if (empty) sstate_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: sstate_d = StIdle;
    endcase
    if (pop) begin
      sstate_d   = StActive;
      cnt_d      = '0;
      cs_n_d     = 1'b0;
      rd_nwr_d   = head.rd_nwr;
      bs_out_d   = head.bs;
      reg_out_d  = head.reg_num;
      data_out_d = head.data;
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
  always_comb begin
    push   = enq && (!full || pop);
    wptr_d = push ? wptr_q + PtrOne : wptr_q;
    rptr_d = pop ? rptr_q + PtrOne : rptr_q;
    ovr_d  = cmd_seen ? 1'b0 : ovr_q;
    if (enq && !push) ovr_d = 1'b1;
    if (cmd_seen) tx_d = IDLE_BYTE;
    else if (capture) tx_d = bus_data_i;
    else tx_d = tx_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PtrW-1:0]] <= enq_entry;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pstate_q   <= StCmd;
      wr_q       <= 1'b0;
      ai_q       <= 1'b0;
      csb_q      <= 1'b0;
      lane_q     <= 1'b0;
      reg_q      <= 4'd0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      sstate_q   <= StIdle;
      cnt_q      <= '0;
      cs_n_q     <= 1'b1;
      rd_nwr_q   <= 1'b1;
      bs_out_q   <= 1'b0;
      reg_out_q  <= 4'd0;
      data_out_q <= 8'h00;
      tx_q       <= IDLE_BYTE;
      soft_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      pstate_q   <= pstate_d;
      wr_q       <= wr_d;
      ai_q       <= ai_d;
      csb_q      <= csb_d;
      lane_q     <= lane_d;
      reg_q      <= reg_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      sstate_q   <= sstate_d;
      cnt_q      <= cnt_d;
      cs_n_q     <= cs_n_d;
      rd_nwr_q   <= rd_nwr_d;
      bs_out_q   <= bs_out_d;
      reg_out_q  <= reg_out_d;
      data_out_q <= data_out_d;
      tx_q       <= tx_d;
      soft_q     <= soft_d;
      ovr_q      <= ovr_d;
    end
  end

  assign spi_tx_byte_o = tx_q;
  assign bus_cs_n_o    = cs_n_q;
  assign bus_rd_nwr_o  = rd_nwr_q;
  assign bus_bytesel_o = bs_out_q;
  assign bus_reg_num_o = reg_out_q;
  assign bus_data_o    = data_out_q;
  assign soft_reset_o  = soft_q;
  assign overrun_o     = ovr_q;

endmodule
